ifu: RTL
========

# ifu

Instruction fetch unit for the riscv64i core, directly upstream of the decoder and the execute stage. It owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC to decode over a valid/ready handshake. It accepts PC redirects (branch, jal, jalr) from the execute stage, discarding wrong-path fetches.

## Interface
- DATA_LEN, 64, PC/address width
- INST_LEN, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  DATA_LEN  fetch address, always 4-aligned
- imem_ack_i  in  1  memory completes request this cycle
- imem_data_i  in  INST_LEN  instruction word, valid when imem_ack_i=1
- imem_err_i  in  1  access fault, valid when imem_ack_i=1
- inst_valid_o  out  1  instruction (or fault) offered to decode
- inst_ready_i  in  1  decode accepts the offered item
- inst_o  out  INST_LEN  instruction word
- pc_o  out  DATA_LEN  PC of inst_o
- fetch_fault_o  out  1  offered item is a fetch fault (access error or misaligned target)
- redirect_i  in  1  execute stage requests a new fetch PC
- redirect_pc_i  in  DATA_LEN  redirect target

## Operation
- Registers: fetch_pc, state, pending_pc, out_inst, out_pc, out_fault.
- States:
  - FETCH: req high.
  - DRAIN: req high, result will be discarded.
  - HOLD: item offered.
  - PARK: idle after a fault until redirect.
- imem_req_o = (state==FETCH or DRAIN) and !rst. imem_addr_o = fetch_pc.
- Once imem_req_o=1, req and addr stay stable until a cycle with imem_ack_i=1. A request is never withdrawn.
- FETCH, ack, no redirect:
  - out_inst=imem_data_i (0 if err), out_pc=fetch_pc, out_fault=imem_err_i.
  - fetch_pc += 4, modulo 2^DATA_LEN.
  - Go to HOLD.
- FETCH, no ack, no redirect: stay.
- HOLD: inst_valid_o=1. On inst_ready_i go to FETCH, or to PARK if out_fault=1.
- Redirect handling (highest priority in every state):
  - Target with redirect_pc_i[1:0]!=0 is misaligned. Instead of fetching, go to HOLD with out_fault=1, out_pc=target, out_inst=0.
  - FETCH, ack same cycle: drop the returned data. fetch_pc=target. Stay in FETCH (new request next cycle).
  - FETCH, no ack: pending_pc=target, go to DRAIN.
  - DRAIN: each redirect overwrites pending_pc (last wins). On ack, drop data, set fetch_pc=pending_pc, go to FETCH. Redirect and ack in the same cycle: the new target is used.
  - HOLD: the offered item is withdrawn. If inst_ready_i is high the same cycle, the item counts as accepted. fetch_pc=target, go to FETCH.
  - PARK: fetch_pc=target, go to FETCH.
- Misaligned handling, in precedence order:
  - Misaligned-target check is applied before the state-specific redirect action.
  - In DRAIN, a misaligned target is stored in pending_pc. It is converted to a fault only after the ack.
- inst_o/pc_o/fetch_fault_o are driven from the out_* registers and are meaningful only while inst_valid_o=1.

## Timing
- Reset values (the cycle rst=1 and the cycle after):
  - imem_req_o=0 during rst.
  - imem_addr_o=RESET_PC.
  - inst_valid_o=0, inst_o=0, pc_o=RESET_PC, fetch_fault_o=0.
  - state=FETCH, fetch_pc=RESET_PC, pending_pc=0.
- First request: imem_req_o=1 in the first cycle with rst=0.
- Reset mid-operation: all state is cleared immediately, including an outstanding request, which is abandoned. Memory must tolerate this.
- Latency: an ack in cycle N gives inst_valid_o=1 in N+1. Acceptance in cycle M gives the next imem_req_o in M+1. Steady state is 2 cycles per instruction with single-cycle ack.
- Redirect in cycle N (no outstanding request, or ack in N): imem_req_o with addr=target in N+1.
- inst_valid_o never drops without inst_ready_i, except on redirect or rst.

## Test plan
- Reset then zero-wait memory:
  - Stimulus: imem_ack_i=1 every cycle, data 0x00000013.
  - Requests to 0x80000000, 0x80000004, 0x80000008.
  - Each offered with pc_o matching, 2 cycles apart, with inst_ready_i=1.
- Decode backpressure:
  - Stimulus: inst_ready_i=0 for 5 cycles after valid.
  - inst_valid_o/inst_o/pc_o stay stable and no new request is issued.
  - On ready, the next request to pc+4 follows one cycle later.
- Redirect during outstanding request:
  - Stimulus: ack delayed 3 cycles; redirect to 0x80000100 in request cycle 1, then redirect to 0x80000200 in cycle 2.
  - Address stays at the old PC until ack.
  - Returned data is never offered.
  - Next request goes to 0x80000200.
- Redirect in HOLD with simultaneous inst_ready_i:
  - Stimulus: redirect to 0x80000040 while an item is offered and inst_ready_i=1.
  - Valid drops next cycle; next request goes to 0x80000040.
- Faults:
  - Access error: imem_err_i=1 with ack gives fetch_fault_o=1, inst_o=0. After acceptance there is no request until a redirect.
  - Misaligned target: redirect to 0x80000102 gives a fault offered with pc_o=0x80000102 and no memory request.
- Wrap and mid-run reset:
  - Redirect to 0xFFFFFFFFFFFFFFFC: after that fetch, the next address is 0x0.
  - Asserting rst while imem_req_o=1 gives req=0, valid=0, and a restart at RESET_PC.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues word fetches over req/ack,
// offers fetched words (or faults) to decode over valid/ready, and follows redirects.
module ifu #(
    parameter int                     DATA_LEN = 64,
    parameter int                     INST_LEN = 32,
    parameter logic [DATA_LEN-1:0]    RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_o,
    output logic [DATA_LEN-1:0] imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [INST_LEN-1:0] imem_data_i,
    input  logic                imem_err_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic [DATA_LEN-1:0] pc_o,
    output logic                fetch_fault_o,
    input  logic                redirect_i,
    input  logic [DATA_LEN-1:0] redirect_pc_i
);

    // Handshakes: a transfer happens on a rising edge where valid (req) and
    // ready (ack) are both high; valid/req and their payload hold until then.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2,
        S_PARK  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_LEN-1:0] pending_pc_q, pending_pc_d;
    logic [INST_LEN-1:0] out_inst_q, out_inst_d;
    logic [DATA_LEN-1:0] out_pc_q, out_pc_d;
    logic                out_fault_q, out_fault_d;

    logic                redir_mis;
    logic [DATA_LEN-1:0] drain_target;
    logic                take_fault;
    logic [DATA_LEN-1:0] fault_pc;

    assign redir_mis    = (redirect_pc_i[1:0] != 2'b00);
    assign drain_target = redirect_i ? redirect_pc_i : pending_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            out_inst_q   <= '0;
            out_pc_q     <= RESET_PC;
            out_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_fault_q  <= out_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_fault_d  = out_fault_q;
        take_fault   = 1'b0;
        fault_pc     = redirect_pc_i;

        case (state_q)
            S_FETCH: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        if (redir_mis) begin
                            take_fault = 1'b1;
                        end else begin
                            fetch_pc_d = redirect_pc_i;
                        end
                    end else begin
                        // Outstanding request cannot be withdrawn; even a misaligned
                        // target waits in pending_pc and faults after the ack.
                        pending_pc_d = redirect_pc_i;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    out_inst_d  = imem_err_i ? '0 : imem_data_i;
                    out_pc_d    = fetch_pc_q;
                    out_fault_d = imem_err_i;
                    fetch_pc_d  = fetch_pc_q + DATA_LEN'(4);
                    state_d     = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    pending_pc_d = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    if (drain_target[1:0] != 2'b00) begin
                        take_fault = 1'b1;
                        fault_pc   = drain_target;
                    end else begin
                        fetch_pc_d = drain_target;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    if (redir_mis) begin
                        take_fault = 1'b1;
                    end else begin
                        fetch_pc_d = redirect_pc_i;
                        state_d    = S_FETCH;
                    end
                end else if (inst_ready_i) begin
                    state_d = out_fault_q ? S_PARK : S_FETCH;
                end
            end
            S_PARK: begin
                if (redirect_i) begin
                    if (redir_mis) begin
                        take_fault = 1'b1;
                    end else begin
                        fetch_pc_d = redirect_pc_i;
                        state_d    = S_FETCH;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (take_fault) begin
            out_fault_d = 1'b1;
            out_pc_d    = fault_pc;
            out_inst_d  = '0;
            state_d     = S_HOLD;
        end
    end

    assign imem_req_o    = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && !rst;
    assign imem_addr_o   = fetch_pc_q;
    assign inst_valid_o  = (state_q == S_HOLD);
    assign inst_o        = out_inst_q;
    assign pc_o          = out_pc_q;
    assign fetch_fault_o = out_fault_q;

endmodule
